// File: rtl/otter_mem_pkg.sv
// Shared types for the OTTER unified-memory arbiter: FSM states,
// transaction owner tag and memory access size encodings.
package otter_mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t SZ_BYTE = 2'b00;
  localparam mem_size_t SZ_HALF = 2'b01;
  localparam mem_size_t SZ_WORD = 2'b10;

endpackage

// File: rtl/otter_mem_arbiter_perf_counter.sv
// 32-bit saturating event counter, used for arbiter stall statistics
// when OTTER_ARB_PERF_CNT_EN is defined.
module arb_perf_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_d, count_q;

  // Advance on each counted cycle, holding at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/otter_mem_arbiter.sv
// Arbiter sharing one memory port between OTTER fetch (IF) and data (MEM)
// stages. One transaction in flight; data side wins unless fetch has lost
// STARVE_LIMIT consecutive arbitrations.
// Optional stall-cycle counters: define OTTER_ARB_PERF_CNT_EN.
module otter_mem_arbiter
  import otter_mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [1:0]        dm_size,
  input  logic              dm_sign,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic              mem_sign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef OTTER_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_wait,
  output logic [31:0]       perf_dm_wait
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  arb_state_t        state_d, state_q;
  owner_t            owner_d, owner_q;
  logic              we_d, we_q;
  mem_size_t         size_d, size_q;
  logic              sign_d, sign_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [3:0]        starve_cnt_d, starve_cnt_q;
  logic              if_wins;
  logic              complete;

  // Next-state, arbitration and field latching; requests only matter in IDLE.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    size_d       = size_q;
    sign_d       = sign_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    starve_cnt_d = starve_cnt_q;
    if_wins      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          if_wins = if_req && (!dm_req || (starve_cnt_q == STARVE_LIM));
          state_d = WAIT_ACK;
          if (if_wins) begin
            owner_d      = OWN_IF;
            we_d         = 1'b0;
            size_d       = SZ_WORD;
            sign_d       = 1'b0;
            addr_d       = if_addr;
            wdata_d      = '0;
            starve_cnt_d = 4'd0;
          end else begin
            owner_d = OWN_DM;
            we_d    = dm_we;
            size_d  = dm_size;
            sign_d  = dm_sign;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
            if (if_req) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end
        end
      end
      WAIT_ACK: begin
        if (mem_ack) begin
          state_d = mem_rvalid ? IDLE : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched-transaction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IF;
      we_q         <= 1'b0;
      size_q       <= SZ_BYTE;
      sign_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      starve_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Response routing: a completion whose requester has gone away is dropped.
  always_comb begin
    complete = mem_rvalid &&
               ((state_q == WAIT_RESP) || ((state_q == WAIT_ACK) && mem_ack));
    if_valid = complete && (owner_q == OWN_IF) && if_req;
    dm_valid = complete && (owner_q == OWN_DM) && dm_req;
    if_rdata = if_valid ? mem_rdata : '0;
    dm_rdata = dm_valid ? mem_rdata : '0;
    if_stall = if_req && !if_valid;
    dm_stall = dm_req && !dm_valid;
  end

  assign mem_req   = (state_q == WAIT_ACK);
  assign mem_we    = we_q;
  assign mem_size  = size_q;
  assign mem_sign  = sign_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef OTTER_ARB_PERF_CNT_EN
  arb_perf_counter u_perf_if (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (if_stall),
    .count (perf_if_wait)
  );

  arb_perf_counter u_perf_dm (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dm_stall),
    .count (perf_dm_wait)
  );
`endif

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Directed scoreboard bench for otter_mem_arbiter. Inputs change on the
// falling edge; outputs are sampled 1 time unit later, before the rising edge.
module tb_otter_mem_arbiter;
  import otter_mem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [1:0]  dm_size;
  logic        dm_sign;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef OTTER_ARB_PERF_CNT_EN
  logic [31:0] perf_if_wait;
  logic [31:0] perf_dm_wait;
`endif

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   waits;

  otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .if_stall   (if_stall),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_size    (dm_size),
    .dm_sign    (dm_sign),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_valid   (dm_valid),
    .dm_stall   (dm_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_size   (mem_size),
    .mem_sign   (mem_sign),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef OTTER_ARB_PERF_CNT_EN
    ,
    .perf_if_wait (perf_if_wait),
    .perf_dm_wait (perf_dm_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so a stuck run still terminates with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                               input logic d_req, input logic d_we,
                               input logic [1:0] d_size, input logic d_sign,
                               input logic [31:0] d_addr, input logic [31:0] d_wdata);
    if_req   = i_req;
    if_addr  = i_addr;
    dm_req   = d_req;
    dm_we    = d_we;
    dm_size  = d_size;
    dm_sign  = d_sign;
    dm_addr  = d_addr;
    dm_wdata = d_wdata;
  endtask

  // Pop the oldest expected completion and compare it with this cycle's outputs.
  task automatic popCheck();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput("if_valid", 32'(if_valid), 32'(e.is_if));
      checkOutput("dm_valid", 32'(dm_valid), 32'(!e.is_if));
      checkOutput("rdata", e.is_if ? if_rdata : dm_rdata, e.data);
      checkOutput("owner_stall_low", 32'(e.is_if ? if_stall : dm_stall), 32'd0);
    end
  endtask

  // Memory model: wait (bounded) for mem_req, check fields, ack, respond.
  // Returns at the falling edge of the cycle after completion, bus quiet.
  task automatic serveMem(input logic [31:0] exp_addr, input logic exp_we,
                          input logic [1:0] exp_size, input logic [31:0] exp_wdata,
                          input logic [31:0] rdata, input bit same_cycle,
                          output int n);
    n = 0;
    while (mem_req !== 1'b1 && n < 8) begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rvalid = 1'b0;
      #1;
      n++;
    end
    checkOutput("mem_req_seen", 32'(mem_req), 32'd1);
    checkOutput("mem_addr", mem_addr, exp_addr);
    checkOutput("mem_we", 32'(mem_we), 32'(exp_we));
    checkOutput("mem_size", 32'(mem_size), 32'(exp_size));
    checkOutput("mem_wdata", mem_wdata, exp_wdata);
    checkOutput("stall_in_wait_ack", 32'(if_stall | dm_stall), 32'd1);
    mem_ack = 1'b1;
    if (same_cycle) begin
      mem_rvalid = 1'b1;
      mem_rdata = rdata;
      #1;
      popCheck();
    end else begin
      #1;
      checkOutput("no_valid_on_ack", 32'(if_valid | dm_valid), 32'd0);
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata = rdata;
      #1;
      checkOutput("mem_req_dropped", 32'(mem_req), 32'd0);
      popCheck();
    end
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    applyStimulus(0, 0, 0, 0, SZ_BYTE, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_dm_valid", 32'(dm_valid), 32'd0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("rst_starve", 32'(dut.starve_cnt_q), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_if_rdata", if_rdata, 32'd0);

    // Fetch only: valid in the third cycle.
    $display("[TB] fetch only");
    @(negedge clk);
    applyStimulus(1, 32'h100, 0, 0, SZ_BYTE, 0, 0, 0);
    #1;
    checkOutput("t1_stall_c1", 32'(if_stall), 32'd1);
    checkOutput("t1_mem_req_c1", 32'(mem_req), 32'd0);
    sb.push_back('{is_if: 1'b1, data: 32'h0000_0013});
    serveMem(32'h100, 1'b0, SZ_WORD, 32'h0, 32'h0000_0013, 1'b0, waits);
    checkOutput("t1_latency", 32'(waits), 32'd1);
    if_req = 1'b0;
    #1;
    checkOutput("t1_valid_gone", 32'(if_valid), 32'd0);

    // Fetch and store together: store first, one idle cycle, then fetch.
    $display("[TB] fetch and store");
    @(negedge clk);
    applyStimulus(1, 32'h200, 1, 1, SZ_WORD, 0, 32'h2000, 32'hDEAD_BEEF);
    #1;
    checkOutput("t2_dm_stall", 32'(dm_stall), 32'd1);
    sb.push_back('{is_if: 1'b0, data: 32'h0});
    sb.push_back('{is_if: 1'b1, data: 32'h0000_0093});
    serveMem(32'h2000, 1'b1, SZ_WORD, 32'hDEAD_BEEF, 32'h0, 1'b0, waits);
    dm_req = 1'b0;
    #1;
    checkOutput("t2_idle_gap", 32'(mem_req), 32'd0);
    checkOutput("t2_if_stall_gap", 32'(if_stall), 32'd1);
    serveMem(32'h200, 1'b0, SZ_WORD, 32'h0, 32'h0000_0093, 1'b0, waits);
    checkOutput("t2_fetch_after_gap", 32'(waits), 32'd1);
    if_req = 1'b0;

    // Starvation: four data wins, then fetch forced through.
    $display("[TB] starvation");
    @(negedge clk);
    applyStimulus(1, 32'h300, 1, 0, SZ_WORD, 0, 32'h1000, 0);
    for (int i = 0; i < 4; i++) begin
      dm_addr = 32'h1000 + 32'(i * 4);
      #1;
      sb.push_back('{is_if: 1'b0, data: 32'hA000 + 32'(i)});
      serveMem(32'h1000 + 32'(i * 4), 1'b0, SZ_WORD, 32'h0, 32'hA000 + 32'(i), 1'b0, waits);
    end
    #1;
    checkOutput("t3_starve_at_limit", 32'(dut.starve_cnt_q), 32'd4);
    sb.push_back('{is_if: 1'b1, data: 32'h0000_0033});
    serveMem(32'h300, 1'b0, SZ_WORD, 32'h0, 32'h0000_0033, 1'b0, waits);
    if_req = 1'b0;
    dm_req = 1'b0;
    #1;
    checkOutput("t3_starve_cleared", 32'(dut.starve_cnt_q), 32'd0);

    // Fetch flushed while in WAIT_RESP: response discarded.
    $display("[TB] fetch flush");
    @(negedge clk);
    applyStimulus(1, 32'h400, 0, 0, SZ_BYTE, 0, 0, 0);
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    checkOutput("t4_mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;
    if_req = 1'b0;
    #1;
    checkOutput("t4_stall_after_drop", 32'(if_stall), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0BAD;
    #1;
    checkOutput("t4_no_if_valid", 32'(if_valid), 32'd0);
    checkOutput("t4_if_rdata_zero", if_rdata, 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    #1;
    checkOutput("t4_back_idle", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, SZ_HALF, 1, 32'h40, 0);
    #1;
    sb.push_back('{is_if: 1'b0, data: 32'h0000_5555});
    serveMem(32'h40, 1'b0, SZ_HALF, 32'h0, 32'h0000_5555, 1'b0, waits);
    checkOutput("t4_mem_sign", 32'(mem_sign), 32'd1);
    dm_req = 1'b0;

    // Ack and rvalid together.
    $display("[TB] same-cycle ack and rvalid");
    @(negedge clk);
    applyStimulus(0, 0, 1, 0, SZ_WORD, 0, 32'h80, 0);
    #1;
    sb.push_back('{is_if: 1'b0, data: 32'h0000_1234});
    serveMem(32'h80, 1'b0, SZ_WORD, 32'h0, 32'h0000_1234, 1'b1, waits);
    dm_req = 1'b0;
    #1;
    checkOutput("t5_back_idle", 32'(dut.state_q), 32'(IDLE));
    checkOutput("t5_mem_req_low", 32'(mem_req), 32'd0);

    // Reset in WAIT_RESP, then a stray rvalid.
    $display("[TB] reset mid-transaction");
    @(negedge clk);
    applyStimulus(1, 32'h500, 0, 0, SZ_BYTE, 0, 0, 0);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    checkOutput("t6_in_wait_resp", 32'(dut.state_q), 32'(WAIT_RESP));
    rst_n = 1'b0;
    if_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("t6_mem_req", 32'(mem_req), 32'd0);
    checkOutput("t6_state", 32'(dut.state_q), 32'(IDLE));
    checkOutput("t6_mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata = 32'h0000_0077;
    #1;
    checkOutput("t6_stray_if_valid", 32'(if_valid), 32'd0);
    checkOutput("t6_stray_dm_valid", 32'(dm_valid), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    checkOutput("t6_still_idle", 32'(dut.state_q), 32'(IDLE));

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
